// File: rtl/write_back_stage_pkg.sv
// Shared definitions for the write-back stage: mem_op encodings, FSM state and the write-pair type.
package write_back_stage_pkg;

   localparam int WB_XLEN   = 32;
   localparam int WB_REG_AW = 5;

   localparam logic [2:0] MEM_NONE = 3'b000;
   localparam logic [2:0] MEM_LW   = 3'b001;
   localparam logic [2:0] MEM_LB   = 3'b010;
   localparam logic [2:0] MEM_LBU  = 3'b011;
   localparam logic [2:0] MEM_LH   = 3'b100;
   localparam logic [2:0] MEM_LHU  = 3'b101;
   localparam logic [2:0] MEM_ST   = 3'b110;
   localparam logic [2:0] MEM_RSVD = 3'b111;

   typedef enum logic [1:0] {
      WB_RUN    = 2'd0,
      WB_HALTED = 2'd1,
      WB_FAULT  = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic                 we;
      logic [WB_REG_AW-1:0] rd;
      logic [WB_XLEN-1:0]   data;
   } wb_write_t;

endpackage

// File: rtl/write_back_stage_if.sv
// Memory-stage to write-back-stage bundle; master is the memory stage, slave is write-back.
interface write_back_stage_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              mm_valid;
   logic              mm_reg_write;
   logic [REG_AW-1:0] mm_rd;
   logic [2:0]        mm_mem_op;
   logic [XLEN-1:0]   mm_alu_result;
   logic [XLEN-1:0]   mm_load_data;
   logic              mm_branch_taken;
   logic [XLEN-1:0]   mm_branch_target;
   logic              mm_halt;

   modport master (
      output mm_valid, mm_reg_write, mm_rd, mm_mem_op, mm_alu_result,
             mm_load_data, mm_branch_taken, mm_branch_target, mm_halt
   );

   modport slave (
      input  mm_valid, mm_reg_write, mm_rd, mm_mem_op, mm_alu_result,
             mm_load_data, mm_branch_taken, mm_branch_target, mm_halt
   );
endinterface

// File: rtl/write_back_stage_load_align.sv
// Combinational load extraction: big-endian lane select, sign/zero extension and alignment check.
module wb_load_align
   import write_back_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      mem_op,
   input  logic [1:0]      addr,
   input  logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] data,
   output logic            write_ok,
   output logic            misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = '0;
      case (addr)
         2'b00:   byte_v = load_data[XLEN-1  -: 8];
         2'b01:   byte_v = load_data[XLEN-9  -: 8];
         2'b10:   byte_v = load_data[XLEN-17 -: 8];
         default: byte_v = load_data[XLEN-25 -: 8];
      endcase
      half_v = addr[1] ? load_data[XLEN-17 -: 16] : load_data[XLEN-1 -: 16];
   end

   always_comb begin
      data       = '0;
      write_ok   = 1'b0;
      misaligned = 1'b0;
      case (mem_op)
         MEM_NONE: write_ok = 1'b1;
         MEM_LW: begin
            write_ok   = 1'b1;
            data       = load_data;
            misaligned = (addr != 2'b00);
         end
         MEM_LB: begin
            write_ok = 1'b1;
            data     = {{(XLEN-8){byte_v[7]}}, byte_v};
         end
         MEM_LBU: begin
            write_ok = 1'b1;
            data     = {{(XLEN-8){1'b0}}, byte_v};
         end
         MEM_LH: begin
            write_ok   = 1'b1;
            data       = {{(XLEN-16){half_v[15]}}, half_v};
            misaligned = addr[0];
         end
         MEM_LHU: begin
            write_ok   = 1'b1;
            data       = {{(XLEN-16){1'b0}}, half_v};
            misaligned = addr[0];
         end
         default: write_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/write_back_stage.sv
// Pipeline write-back stage: register-file write, branch redirect, retire counter, halt/fault FSM.
// Optional macro WB_FORWARD_EN enables the same-cycle forward to decode (tied to 0 otherwise).
module write_back_stage
   import write_back_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   write_back_stage_if.slave  mm,
   output logic               rf_we,
   output logic [REG_AW-1:0]  rf_waddr,
   output logic [XLEN-1:0]    rf_wdata,
   output logic               fwd_valid,
   output logic [REG_AW-1:0]  fwd_rd,
   output logic [XLEN-1:0]    fwd_data,
   output logic               br_valid,
   output logic [XLEN-1:0]    br_target,
   output logic               halted,
   output logic               fault,
   output logic [CNT_W-1:0]   retired_count
);

   logic              e_valid;
   logic              e_reg_write;
   logic [REG_AW-1:0] e_rd;
   logic [2:0]        e_mem_op;
   logic [XLEN-1:0]   e_alu;
   logic [XLEN-1:0]   e_load;
   logic              e_br_taken;
   logic [XLEN-1:0]   e_br_target;
   logic              e_halt;
   logic              consumed;
   wb_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   br_last;

   logic [XLEN-1:0]   ld_data;
   logic              wr_ok;
   logic              mis;
   logic              active;
   wb_write_t         wr;

   wb_load_align #(.XLEN(XLEN)) u_align (
      .mem_op     (e_mem_op),
      .addr       (e_alu[1:0]),
      .load_data  (e_load),
      .data       (ld_data),
      .write_ok   (wr_ok),
      .misaligned (mis)
   );

   // An entry is live only once: consumed is set by any edge that does not load a new entry.
   always_comb begin
      active  = e_valid & ~consumed & enable & (state == WB_RUN);
      wr.we   = active & e_reg_write & (e_rd != '0) & wr_ok & ~mis;
      wr.rd   = e_rd;
      wr.data = (e_mem_op == MEM_NONE) ? e_alu : ld_data;
   end

   assign rf_we         = wr.we;
   assign rf_waddr      = wr.rd;
   assign rf_wdata      = wr.data;
   assign br_valid      = active & e_br_taken & ~mis;
   assign br_target     = br_valid ? e_br_target : br_last;
   assign halted        = (state == WB_HALTED);
   assign fault         = (state == WB_FAULT);
   assign retired_count = cnt;

`ifdef WB_FORWARD_EN
   assign fwd_valid = wr.we;
   assign fwd_rd    = wr.rd;
   assign fwd_data  = wr.data;
`else
   assign fwd_valid = 1'b0;
   assign fwd_rd    = '0;
   assign fwd_data  = '0;
`endif

   // A committing halt or fault entry blocks the capture on the same edge, so nothing follows it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_valid     <= 1'b0;
         e_reg_write <= 1'b0;
         e_rd        <= '0;
         e_mem_op    <= MEM_NONE;
         e_alu       <= '0;
         e_load      <= '0;
         e_br_taken  <= 1'b0;
         e_br_target <= '0;
         e_halt      <= 1'b0;
         consumed    <= 1'b0;
         state       <= WB_RUN;
         cnt         <= '0;
         br_last     <= '0;
      end else if (enable) begin
         if (state == WB_RUN) begin
            br_last <= br_target;
            if (active && mis) begin
               state <= WB_FAULT;
            end else begin
               if (active)
                  cnt <= cnt + CNT_W'(1);
               if (active && e_halt) begin
                  state <= WB_HALTED;
               end else begin
                  e_valid     <= mm.mm_valid;
                  e_reg_write <= mm.mm_reg_write;
                  e_rd        <= mm.mm_rd;
                  e_mem_op    <= mm.mm_mem_op;
                  e_alu       <= mm.mm_alu_result;
                  e_load      <= mm.mm_load_data;
                  e_br_taken  <= mm.mm_branch_taken;
                  e_br_target <= mm.mm_branch_target;
                  e_halt      <= mm.mm_halt;
                  consumed    <= 1'b0;
               end
            end
         end
      end else begin
         consumed <= 1'b1;
      end
   end

endmodule
